mips_bus_sequencer: RTL and testbench

// Sequences a single Avalon-style memory bus (waitrequest, read latency 1) between the core's

---
 rtl/mips_bus_pkg.sv | 29 ++
 rtl/mips_bus_if.sv | 22 ++
 rtl/bus_watchdog.sv | 30 +++
 rtl/mips_bus_sequencer.sv | 159 +++++++++++++++
 tb/tb_mips_bus_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus sequencer: FSM state encoding and the registered bus request.
package mips_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FETCH_RESP,
      S_EXEC,
      S_DATA,
      S_DATA_RESP,
      S_HALTED,
      S_ERROR
   } state_t;

   localparam logic [3:0] BE_WORD = 4'hF;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        rd;
      logic        wr;
   } bus_req_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mips_bus_if.sv
// Avalon-style unified memory bus (waitrequest, read latency 1).
interface mips_bus_if;

   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata
   );

endinterface

// File: rtl/bus_watchdog.sv
// Counts consecutive stalled bus cycles; flags expiry so the sequencer can abandon the transfer.
module bus_watchdog #(
   parameter int unsigned WAIT_TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_counting,
   input  logic i_wait,
   output logic o_expire
);

   localparam int unsigned CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_enable) begin
         if (i_counting && i_wait) r_count <= r_count + CW'(1);
         else                      r_count <= '0;
      end
   end

   // The current stalled cycle is included, so expiry fires on the WAIT_TIMEOUT-th stall.
   assign o_expire = (WAIT_TIMEOUT != 0) && i_counting && i_wait && (r_count == LIMIT);

endmodule

// File: rtl/mips_bus_sequencer.sv
// Sequences one fetch and at most one data access per instruction over a single Avalon bus.
module mips_bus_sequencer
   import mips_bus_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic [31:0] dm_addr,
   input  logic        dm_read,
   input  logic        dm_write,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_byteenable,
   output logic [31:0] dm_rdata,
   input  logic        halt,
   output logic        commit,
   output logic        active,
   output logic        err,
   mips_bus_if.master  bus
);

   state_t      r_state;
   bus_req_t    r_req;
   logic [31:0] r_if_rdata;
   logic [31:0] r_dm_rdata;
   logic        r_if_valid;
   logic        r_active;
   logic        r_err;
   logic        w_counting;
   logic        w_expire;
   logic        w_commit;

   assign w_counting = (r_state == S_FETCH) || (r_state == S_DATA);

   bus_watchdog #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_watchdog (
      .clk        (clk),
      .rst_n      (reset),
      .i_enable   (clk_enable),
      .i_counting (w_counting),
      .i_wait     (bus.waitrequest),
      .o_expire   (w_expire)
   );

   always_comb begin
      w_commit = 1'b0;
      case (r_state)
         S_EXEC:      w_commit = !halt && !dm_read && !dm_write;
         S_DATA:      w_commit = r_req.wr && !bus.waitrequest;
         S_DATA_RESP: w_commit = 1'b1;
         default:     w_commit = 1'b0;
      endcase
   end

   // Gated so a frozen cycle cannot present the strobe more than once.
   assign commit   = w_commit && clk_enable;
   assign dm_rdata = (r_state == S_DATA_RESP) ? bus.readdata : r_dm_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_req      <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
         r_if_valid <= 1'b0;
         r_active   <= 1'b1;
         r_err      <= 1'b0;
      end else if (clk_enable) begin
         if (w_expire) begin
            r_state    <= S_ERROR;
            r_req.rd   <= 1'b0;
            r_req.wr   <= 1'b0;
            r_err      <= 1'b1;
            r_active   <= 1'b0;
            r_if_valid <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_req.addr <= word_align(if_addr);
                  r_req.be   <= BE_WORD;
                  r_req.rd   <= 1'b1;
                  r_req.wr   <= 1'b0;
                  r_state    <= S_FETCH;
               end
               S_FETCH: begin
                  if (!bus.waitrequest) begin
                     r_req.rd <= 1'b0;
                     r_state  <= S_FETCH_RESP;
                  end
               end
               S_FETCH_RESP: begin
                  r_if_rdata <= bus.readdata;
                  r_if_valid <= 1'b1;
                  r_state    <= S_EXEC;
               end
               S_EXEC: begin
                  if (halt) begin
                     r_state    <= S_HALTED;
                     r_active   <= 1'b0;
                     r_if_valid <= 1'b0;
                  end else if (dm_write) begin
                     r_req.addr  <= word_align(dm_addr);
                     r_req.wdata <= dm_wdata;
                     r_req.be    <= dm_byteenable;
                     r_req.rd    <= 1'b0;
                     r_req.wr    <= 1'b1;
                     if (dm_read) r_err <= 1'b1;
                     r_state     <= S_DATA;
                  end else if (dm_read) begin
                     r_req.addr <= word_align(dm_addr);
                     r_req.be   <= dm_byteenable;
                     r_req.rd   <= 1'b1;
                     r_req.wr   <= 1'b0;
                     r_state    <= S_DATA;
                  end else begin
                     r_if_valid <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
               S_DATA: begin
                  if (!bus.waitrequest) begin
                     r_req.rd <= 1'b0;
                     r_req.wr <= 1'b0;
                     if (r_req.wr) begin
                        r_if_valid <= 1'b0;
                        r_state    <= S_IDLE;
                     end else begin
                        r_state <= S_DATA_RESP;
                     end
                  end
               end
               S_DATA_RESP: begin
                  r_dm_rdata <= bus.readdata;
                  r_if_valid <= 1'b0;
                  r_state    <= S_IDLE;
               end
               default: begin
                  r_req.rd <= 1'b0;
                  r_req.wr <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.address    = r_req.addr;
   assign bus.read       = r_req.rd;
   assign bus.write      = r_req.wr;
   assign bus.byteenable = r_req.be;
   assign bus.writedata  = r_req.wdata;
   assign if_rdata       = r_if_rdata;
   assign if_valid       = r_if_valid;
   assign active         = r_active;
   assign err            = r_err;

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Directed bench for mips_bus_sequencer with hand-computed expectations.
module tb_mips_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic [31:0] dm_addr;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_byteenable;
   logic [31:0] dm_rdata;
   logic        halt;
   logic        commit;
   logic        active;
   logic        err;

   int unsigned total = 0;
   int unsigned bad   = 0;

   mips_bus_if bus();

   always #5 clk = ~clk;

   mips_bus_sequencer #(.WAIT_TIMEOUT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_enable    (clk_enable),
      .if_addr       (if_addr),
      .if_rdata      (if_rdata),
      .if_valid      (if_valid),
      .dm_addr       (dm_addr),
      .dm_read       (dm_read),
      .dm_write      (dm_write),
      .dm_wdata      (dm_wdata),
      .dm_byteenable (dm_byteenable),
      .dm_rdata      (dm_rdata),
      .halt          (halt),
      .commit        (commit),
      .active        (active),
      .err           (err),
      .bus           (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dm(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic h);
      dm_read       = rd;
      dm_write      = wr;
      dm_addr       = a;
      dm_wdata      = wd;
      dm_byteenable = be;
      halt          = h;
   endtask

   // Called in an IDLE cycle; returns positioned in EXEC.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
      if_addr         = pc;
      bus.readdata    = instr;
      bus.waitrequest = 1'b0;
      tick();
      check("fetch_read", bus.read, 1);
      check("fetch_addr", bus.address, pc);
      check("fetch_be", bus.byteenable, 4'hF);
      tick();
      check("fresp_read", bus.read, 0);
      tick();
      check("exec_ir", if_rdata, instr);
      check("exec_valid", if_valid, 1);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      check("rst_active", active, 1);
      check("rst_err", err, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog_time got=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      reset           = 1'b0;
      clk_enable      = 1'b1;
      if_addr         = '0;
      bus.waitrequest = 1'b0;
      bus.readdata    = '0;
      set_dm(0, 0, 32'h0, 32'h0, 4'h0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_read", bus.read, 0);
      check("rst_write", bus.write, 0);
      check("rst_addr", bus.address, 0);
      check("rst_be", bus.byteenable, 0);
      check("rst_wdata", bus.writedata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      check("rst_commit", commit, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_err", err, 0);
      check("rst_active", active, 1);
      reset = 1'b1;

      // ALU op, no waits
      set_dm(0, 0, 32'h0, 32'h0, 4'h0, 0);
      fetch(32'hBFC0_0000, 32'h2402_0005);
      check("alu_commit", commit, 1);
      check("alu_nowrite", bus.write, 0);
      tick();
      check("alu_idle_commit", commit, 0);
      check("alu_idle_valid", if_valid, 0);
      check("alu_ir_hold", if_rdata, 32'h2402_0005);

      // Load with three stall cycles
      set_dm(1, 0, 32'h0000_1003, 32'h0, 4'hF, 0);
      fetch(32'hBFC0_0004, 32'h8C03_1003);
      check("ld_exec_commit", commit, 0);
      bus.readdata    = 32'hCAFE_F00D;
      bus.waitrequest = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.waitrequest = 1'b0;
         #1;
         check("ld_read", bus.read, 1);
         check("ld_addr", bus.address, 32'h0000_1000);
         check("ld_commit", commit, 0);
         tick();
      end
      check("ld_resp_read", bus.read, 0);
      check("ld_resp_commit", commit, 1);
      check("ld_resp_data", dm_rdata, 32'hCAFE_F00D);
      tick();
      bus.readdata = 32'h0;
      #1;
      check("ld_idle_commit", commit, 0);
      check("ld_data_hold", dm_rdata, 32'hCAFE_F00D);

      // Store, half-word lanes, one stall
      set_dm(0, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 0);
      fetch(32'hBFC0_0008, 32'hAC04_2004);
      check("st_exec_commit", commit, 0);
      bus.waitrequest = 1'b1;
      tick();
      check("st_write", bus.write, 1);
      check("st_read", bus.read, 0);
      check("st_be", bus.byteenable, 4'b0011);
      check("st_wdata", bus.writedata, 32'hDEAD_BEEF);
      check("st_addr", bus.address, 32'h0000_2004);
      check("st_wait_commit", commit, 0);
      bus.waitrequest = 1'b0;
      #1;
      check("st_commit", commit, 1);
      tick();
      check("st_idle_write", bus.write, 0);
      check("st_idle_commit", commit, 0);

      // Clock-enable freeze in DATA with the bus ready
      set_dm(0, 1, 32'h0000_4000, 32'h0BAD_F00D, 4'hF, 0);
      fetch(32'hBFC0_000C, 32'hAC05_4000);
      tick();
      clk_enable = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("frz_write", bus.write, 1);
         check("frz_addr", bus.address, 32'h0000_4000);
         check("frz_commit", commit, 0);
         tick();
      end
      clk_enable = 1'b1;
      #1;
      check("frz_resume_commit", commit, 1);
      tick();
      check("frz_idle_write", bus.write, 0);
      check("frz_idle_commit", commit, 0);

      // Halt beats a pending store
      set_dm(0, 1, 32'h0000_5000, 32'h1111_1111, 4'hF, 1);
      fetch(32'hBFC0_0010, 32'h0000_0008);
      check("halt_exec_commit", commit, 0);
      tick();
      check("halt_active", active, 0);
      check("halt_write", bus.write, 0);
      check("halt_valid", if_valid, 0);
      repeat (3) tick();
      check("halt_stay_active", active, 0);
      check("halt_stay_read", bus.read, 0);
      check("halt_stay_commit", commit, 0);
      pulse_reset();

      // Conflicting read+write: store wins, err set
      set_dm(1, 1, 32'h0000_6000, 32'h1234_5678, 4'hF, 0);
      fetch(32'hBFC0_0000, 32'hAC06_6000);
      check("rw_exec_err", err, 0);
      tick();
      check("rw_write", bus.write, 1);
      check("rw_read", bus.read, 0);
      check("rw_wdata", bus.writedata, 32'h1234_5678);
      check("rw_err", err, 1);
      check("rw_commit", commit, 1);
      tick();
      check("rw_err_sticky", err, 1);
      check("rw_active", active, 1);
      pulse_reset();

      // Watchdog expiry in FETCH
      set_dm(0, 0, 32'h0, 32'h0, 4'h0, 0);
      if_addr         = 32'h0000_7000;
      bus.waitrequest = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("wd_read", bus.read, 1);
         check("wd_active", active, 1);
         tick();
      end
      check("wd_err_read", bus.read, 0);
      check("wd_err", err, 1);
      check("wd_active_low", active, 0);
      bus.waitrequest = 1'b0;
      repeat (2) tick();
      check("wd_stay_read", bus.read, 0);
      check("wd_stay_active", active, 0);
      pulse_reset();

      // Asynchronous reset mid-fetch
      if_addr         = 32'h0000_8000;
      bus.waitrequest = 1'b1;
      tick();
      check("arst_read_pre", bus.read, 1);
      tick();
      check("arst_read_pre2", bus.read, 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_read", bus.read, 0);
      check("arst_addr", bus.address, 0);
      bus.waitrequest = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
